// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder built around a single full_adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_cout;
  full_adder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_s),
    .cout(w_cout)
  );
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? ((r_cnt == LAST) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Sum fills from the MSB side so that after WIDTH shifts the first computed bit sits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && start) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_cout <= w_cout;
    end
  end
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random additions; a negedge monitor checks results against a queue.
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  logic [W:0]   q_exp[$];
  int           q_cyc[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q_exp.size() == 0) begin
        chk(1'b0, "unexpected_done", {23'd0, cout, sum}, 32'd0);
      end else begin
        logic [W:0] e;
        int c;
        e = q_exp.pop_front();
        c = q_cyc.pop_front();
        chk({cout, sum} == e, "result", {23'd0, cout, sum}, {23'd0, e});
        chk(cyc - c == W && !busy, "latency", cyc - c, W);
      end
    end
  end

  task automatic wait_done();
    int nb = 0;
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) nb++;
      if (done) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk(got, "done_timeout", {31'd0, got}, 1);
    chk(nb == W, "busy_cycles", nb, W);
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic [W:0] exp, input bit scramble, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q_exp.push_back(exp);
    q_cyc.push_back(cyc);
    if (scramble) begin
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b0;
    end
    wait_done();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #1;
    chk(!busy && !done && sum == 0 && !cout, "reset_state", {22'd0, busy, done, cout, sum}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    op(8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 0);
    op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1);
    op(8'h5A, 8'h3C, 1'b1, 9'h097, 1'b1, 0);
    chk(sum == 8'h97 && !cout, "hold_idle", {23'd0, cout, sum}, 9'h097);
    // Start held high through SHIFT/DONE: only one op, then a fresh accept once back in IDLE.
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    q_exp.push_back(9'h1FF);
    q_cyc.push_back(cyc);
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    wait_done();
    @(posedge clk);
    #1;
    chk(!busy && !done, "idle_after_done", {30'd0, busy, done}, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    q_exp.push_back(9'h030);
    q_cyc.push_back(cyc);
    wait_done();
    @(posedge clk);
    #1;
    // Asynchronous reset in the middle of SHIFT aborts without a done pulse.
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk(!busy && !done && sum == 0 && !cout, "async_reset", {22'd0, busy, done, cout, sum}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk(!busy && !done, "no_done_after_abort", {30'd0, busy, done}, 0);
    op(8'h01, 8'h02, 1'b0, 9'h003, 1'b0, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1'($urandom), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #1;
    chk(q_exp.size() == 0, "queue_drained", q_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
